// File: rtl/sonuc_bcd_cevirici_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sonuc_bcd_cevirici_if                                                 |
// | Start/ready/valid bus between a result producer and the BCD formatter |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface sonuc_bcd_cevirici_if #(
  parameter int FRAC_DIGITS = 4
);
  logic                       basla;
  logic [63:0]                sonuc_in;
  logic                       tasma_in;
  logic                       hazir;
  logic                       gecerli;
  logic                       isaret;
  logic [39:0]                tam_bcd;
  logic [4*FRAC_DIGITS-1:0]   kusurat_bcd;
  logic                       hata;

  modport master (
    output basla, sonuc_in, tasma_in,
    input  hazir, gecerli, isaret, tam_bcd, kusurat_bcd, hata
  );

  modport slave (
    input  basla, sonuc_in, tasma_in,
    output hazir, gecerli, isaret, tam_bcd, kusurat_bcd, hata
  );
endinterface
`default_nettype wire

// File: rtl/sonuc_bcd_cevirici.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sonuc_bcd_cevirici                                                    |
// | Q32.32 two's-complement -> sign + 10 integer / FRAC_DIGITS BCD digits |
// | Optional macro YUVARLAMA_EN: guard digit and round-half-up stage.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sonuc_bcd_cevirici #(
  parameter int FRAC_DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  sonuc_bcd_cevirici_if.slave bus
);

`ifdef YUVARLAMA_EN
  localparam int NDIG = FRAC_DIGITS + 1;
`else
  localparam int NDIG = FRAC_DIGITS;
`endif
  localparam int FW = 4 * FRAC_DIGITS;
  localparam int DW = 4 * NDIG;

  typedef enum logic [2:0] {
    BOS     = 3'd0,
    MUTLAK  = 3'd1,
    TAM     = 3'd2,
    KESIR   = 3'd3,
`ifdef YUVARLAMA_EN
    YUVARLA = 3'd4,
`endif
    BITTI   = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [63:0]    mag_q, mag_d;
  logic           tasma_q, tasma_d;
  logic           sign_q, sign_d;
  logic [39:0]    bcd_q, bcd_d;
  logic [DW-1:0]  dig_q, dig_d;
  logic [5:0]     cnt_q, cnt_d;
  logic           isaret_q, isaret_d;
  logic [39:0]    tam_q, tam_d;
  logic [FW-1:0]  kus_q, kus_d;
  logic           hata_q, hata_d;

  logic [39:0]    bcd_adj;
  logic [35:0]    prod;
  logic [3:0]     digit;
  logic [DW-1:0]  dig_shift;

  // Double-dabble correction applied to every nibble before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_dabble
      assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                  (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
    end
  endgenerate

  // After the 32 integer shifts the fraction sits in mag_q[63:32].
  assign prod      = {4'd0, mag_q[63:32]} * 36'd10;
  assign digit     = prod[35:32];
  assign dig_shift = DW'({dig_q, digit});

`ifdef YUVARLAMA_EN
  localparam int RW = 40 + FW;

  logic [RW-1:0] round_in;
  logic [RW-1:0] round_out;
  logic          round_carry;
  logic          rc;
  logic [3:0]    rnib;

  // Round half up on the guard digit, carrying through fraction into integer.
  always_comb begin
    round_in    = {bcd_q, dig_q[DW-1:4]};
    round_out   = '0;
    rc          = (dig_q[3:0] >= 4'd5);
    rnib        = 4'd0;
    for (int i = 0; i < RW / 4; i++) begin
      rnib = round_in[4*i +: 4] + {3'd0, rc};
      if (rnib == 4'd10) begin
        round_out[4*i +: 4] = 4'd0;
        rc                  = 1'b1;
      end else begin
        round_out[4*i +: 4] = rnib;
        rc                  = 1'b0;
      end
    end
    round_carry = rc;
  end
`endif

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    tasma_d  = tasma_q;
    sign_d   = sign_q;
    bcd_d    = bcd_q;
    dig_d    = dig_q;
    cnt_d    = cnt_q;
    isaret_d = isaret_q;
    tam_d    = tam_q;
    kus_d    = kus_q;
    hata_d   = hata_q;

    case (state_q)
      BOS: begin
        if (bus.basla) begin
          mag_d   = bus.sonuc_in;
          tasma_d = bus.tasma_in;
          state_d = MUTLAK;
        end
      end

      MUTLAK: begin
        cnt_d = 6'd0;
        bcd_d = 40'd0;
        dig_d = '0;
        if (tasma_q) begin
          isaret_d = 1'b0;
          tam_d    = 40'd0;
          kus_d    = '0;
          hata_d   = 1'b1;
          state_d  = BITTI;
        end else begin
          sign_d  = mag_q[63];
          mag_d   = mag_q[63] ? (~mag_q + 64'd1) : mag_q;
          state_d = TAM;
        end
      end

      TAM: begin
        bcd_d = {bcd_adj[38:0], mag_q[63]};
        mag_d = {mag_q[62:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          cnt_d   = 6'd0;
          state_d = KESIR;
        end
      end

      KESIR: begin
        mag_d[63:32] = prod[31:0];
        dig_d        = dig_shift;
        cnt_d        = cnt_q + 6'd1;
        if (cnt_q == 6'(NDIG - 1)) begin
`ifdef YUVARLAMA_EN
          state_d  = YUVARLA;
`else
          isaret_d = sign_q;
          tam_d    = bcd_q;
          kus_d    = dig_shift;
          hata_d   = 1'b0;
          state_d  = BITTI;
`endif
        end
      end

`ifdef YUVARLAMA_EN
      YUVARLA: begin
        isaret_d = sign_q;
        tam_d    = round_out[RW-1 -: 40];
        kus_d    = round_out[FW-1:0];
        hata_d   = round_carry;
        state_d  = BITTI;
      end
`endif

      BITTI: begin
        state_d = BOS;
      end

      default: begin
        state_d = BOS;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BOS;
      mag_q    <= 64'd0;
      tasma_q  <= 1'b0;
      sign_q   <= 1'b0;
      bcd_q    <= 40'd0;
      dig_q    <= '0;
      cnt_q    <= 6'd0;
      isaret_q <= 1'b0;
      tam_q    <= 40'd0;
      kus_q    <= '0;
      hata_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      tasma_q  <= tasma_d;
      sign_q   <= sign_d;
      bcd_q    <= bcd_d;
      dig_q    <= dig_d;
      cnt_q    <= cnt_d;
      isaret_q <= isaret_d;
      tam_q    <= tam_d;
      kus_q    <= kus_d;
      hata_q   <= hata_d;
    end
  end

  assign bus.hazir       = (state_q == BOS);
  assign bus.gecerli     = (state_q == BITTI);
  assign bus.isaret      = isaret_q;
  assign bus.tam_bcd     = tam_q;
  assign bus.kusurat_bcd = kus_q;
  assign bus.hata        = hata_q;

endmodule
`default_nettype wire
